uart_key_decoder: RTL and testbench
===================================

Name: uart_key_decoder

Overview:
Sits directly downstream of the UART receiver. Consumes its one-cycle rx_data_valid/rx_data byte strobes and decodes VT100/ANSI escape sequences into 9-bit key codes. Buffers decoded keys in an internal FIFO and presents them to the editor core through a valid/ready interface. The UART side has no backpressure, so overflow is detected and flagged.

Parameters:
FIFO_DEPTH, 16, key FIFO entries; power of two, minimum 2.
ESC_TIMEOUT, 5000, clk cycles of silence after which a lone ESC is emitted, or a partial CSI is aborted.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_data_valid  in  1  one-cycle strobe from the UART receiver
rx_data  in  8  received byte, valid only with the strobe
key_valid  out  1  FIFO non-empty
key_code  out  9  FIFO head (first-word fall-through); bit8=1 means special key
key_ready  in  1  consumer accepts the head when key_valid=1
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
overflow  out  1  sticky: set when a decoded key is lost
overflow_clr  in  1  clears overflow; a same-cycle set wins

Behaviour:
- Reset: key_valid=0, key_code=0, fifo_count=0, overflow=0, FSM=IDLE, timeout counter=0, pending replay cleared.
- Key codes: plain bytes map to {1'b0,byte}. Specials: UP=0x100, DOWN=0x101, RIGHT=0x102, LEFT=0x103, HOME=0x104, END=0x105, DELETE=0x106, ESC=0x107.
- Latency: the FIFO push happens on the clock edge after the byte's strobe cycle. key_valid rises one cycle after the push.
- FSM states:
  - IDLE: byte 0x1B -> ESC. Any other byte is pushed as a plain key.
  - ESC: '[' -> CSI. Any other byte: push ESC now; replay that byte in IDLE on the next cycle through a 1-entry pending register. Timeout: push ESC, go to IDLE.
  - CSI: 'A','B','C','D' push UP, DOWN, RIGHT, LEFT. 'H' pushes HOME; 'F' pushes END. Each of these returns to IDLE.
  - CSI, continued: '0'-'9' or ';' -> PARAM; store the digit and set param_len=1. Any other final byte 0x40-0x7E is dropped silently -> IDLE. A byte outside 0x20-0x7E aborts -> IDLE with no push.
  - PARAM: '0'-'9' or ';' increment param_len (saturating at 2). '~' with param_len=1 and digit '1' pushes HOME, '3' pushes DELETE, '4' pushes END. Every other '~' or final byte is dropped -> IDLE. Abort rule is the same as CSI.
- Timeout counter: resets on every accepted byte and runs only in ESC, CSI and PARAM. It fires when count==ESC_TIMEOUT-1. In CSI or PARAM it aborts silently -> IDLE.
- FIFO:
  - Pop occurs when key_valid && key_ready.
  - Push succeeds if not full, or if full and a pop happens the same cycle; fifo_count is then unchanged.
  - A push while full with no pop drops the key and sets overflow.
  - Pop while empty is ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Simultaneous events: overflow_clr and a new overflow in the same cycle leave overflow=1. A byte strobe arriving during a pending replay is an upstream contract violation; the replay wins and the strobe byte is dropped with overflow set.
- Reset mid-sequence discards FSM state and FIFO contents immediately.

Optional Feature:
KEY_DROP_CNT_EN: when defined, adds output drop_cnt[7:0]. It is a saturating count (max 255) of every key lost to overflow plus every CSI sequence dropped or aborted. It is cleared by reset and by overflow_clr. When undefined, the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package key_defs_pkg holds:
  - key code constants (KEY_UP..KEY_ESC)
  - byte constants (ASCII_ESC=0x1B, '[', '~')
  - FSM state enum {IDLE, ESC, CSI, PARAM}
  - key_code_t (9 bits)
- Sub-module key_fifo (synchronous FWFT FIFO with parameter DEPTH, push/pop/full/empty/count) is instantiated once. The decoder FSM stays in the top.

Test Plan:
- Bytes 0x61,0x0D one each 50 cycles, key_ready=1 -> key_code 0x061 then 0x00D; each key_valid appears 2 cycles after its strobe.
- 0x1B,'[','A' then 0x1B,'[','3','~' -> exactly two keys: 0x100 then 0x106; no plain bytes emitted.
- Lone 0x1B then idle, ESC_TIMEOUT=20 -> 0x107 pushed on cycle 20 after the strobe. 0x1B followed by 'x' -> 0x107 then 0x078 on consecutive cycles.
- 0x1B,'[','1',';','5','C' -> nothing pushed, FSM back in IDLE. With KEY_DROP_CNT_EN, drop_cnt=1.
- FIFO_DEPTH=4, key_ready=0, 5 plain bytes -> fifo_count=4, overflow=1, head is the first byte. Then key_ready=1 plus overflow_clr -> 4 keys in order, overflow=0.
- Reset asserted after 0x1B,'[' with 2 keys queued -> key_valid=0 and fifo_count=0 immediately. A subsequent 'A' yields 0x041, not UP.

Source files
------------

// File: rtl/key_defs_pkg.sv
// Shared key codes, byte constants and decoder state type for the UART key decoder.
// Helper predicates classify bytes inside a CSI sequence.
package key_defs_pkg;

  typedef logic [8:0] key_code_t;

  localparam key_code_t KEY_UP     = 9'h100;
  localparam key_code_t KEY_DOWN   = 9'h101;
  localparam key_code_t KEY_RIGHT  = 9'h102;
  localparam key_code_t KEY_LEFT   = 9'h103;
  localparam key_code_t KEY_HOME   = 9'h104;
  localparam key_code_t KEY_END    = 9'h105;
  localparam key_code_t KEY_DELETE = 9'h106;
  localparam key_code_t KEY_ESC    = 9'h107;

  localparam logic [7:0] ASCII_ESC      = 8'h1B;
  localparam logic [7:0] ASCII_LBRACKET = 8'h5B;
  localparam logic [7:0] ASCII_TILDE    = 8'h7E;

  typedef enum logic [1:0] {IDLE, ESC, CSI, PARAM} dec_state_t;

  function automatic logic is_param_byte(input logic [7:0] b);
    return ((b >= 8'h30) && (b <= 8'h39)) || (b == 8'h3B);
  endfunction

  function automatic logic is_final_byte(input logic [7:0] b);
    return (b >= 8'h40) && (b <= 8'h7E);
  endfunction

  // Anything outside the printable range terminates a CSI sequence.
  function automatic logic is_csi_byte(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/key_fifo.sv
// First-word fall-through key FIFO; head is shown combinationally, zero when empty.
// A push while full succeeds only when a pop happens on the same edge.
module key_fifo
  import key_defs_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  key_code_t                i_data,
  input  logic                     i_pop,
  output key_code_t                o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  key_code_t        r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Power-of-two depth lets the pointers wrap on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/uart_key_decoder.sv
// Decodes VT100/ANSI escape sequences from UART byte strobes into 9-bit key codes and queues them.
// Optional KEY_DROP_CNT_EN adds o_drop_cnt, a saturating count of lost keys and dropped CSI sequences.
module uart_key_decoder
  import key_defs_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int ESC_TIMEOUT = 5000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_rx_data_valid,
  input  logic [7:0]                    i_rx_data,
  output logic                          o_key_valid,
  output logic [8:0]                    o_key_code,
  input  logic                          i_key_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_overflow,
  input  logic                          i_overflow_clr
`ifdef KEY_DROP_CNT_EN
  ,
  output logic [7:0]                    o_drop_cnt
`endif
);

  localparam int              TMO_W    = $clog2(ESC_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ESC_TIMEOUT - 1);

  dec_state_t        r_state, w_state_next;
  logic [TMO_W-1:0]  r_tmo_cnt, w_tmo_next;
  logic              r_pend_valid, w_pend_valid_next;
  logic [7:0]        r_pend_data, w_pend_data_next;
  logic [7:0]        r_param_digit, w_param_digit_next;
  logic [1:0]        r_param_len, w_param_len_next;
  logic              r_push, w_push;
  key_code_t         r_push_code, w_push_code;
  logic              r_overflow;

  logic              w_byte_valid;
  logic [7:0]        w_byte;
  logic              w_strobe_lost;
  logic              w_tmo_fire;
  logic              w_csi_drop;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_fifo_drop;
  key_code_t         w_head;

  // A replayed byte takes the decode slot; a strobe colliding with it is lost.
  assign w_byte_valid  = r_pend_valid | i_rx_data_valid;
  assign w_byte        = r_pend_valid ? r_pend_data : i_rx_data;
  assign w_strobe_lost = r_pend_valid & i_rx_data_valid;
  assign w_tmo_fire    = (r_state != IDLE) && (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_tmo_cnt     <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_data   <= '0;
      r_param_digit <= '0;
      r_param_len   <= '0;
      r_push        <= 1'b0;
      r_push_code   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_tmo_cnt     <= w_tmo_next;
      r_pend_valid  <= w_pend_valid_next;
      r_pend_data   <= w_pend_data_next;
      r_param_digit <= w_param_digit_next;
      r_param_len   <= w_param_len_next;
      r_push        <= w_push;
      r_push_code   <= w_push_code;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_tmo_next         = (r_state == IDLE) ? '0 : r_tmo_cnt + TMO_W'(1);
    w_pend_valid_next  = 1'b0;
    w_pend_data_next   = r_pend_data;
    w_param_digit_next = r_param_digit;
    w_param_len_next   = r_param_len;
    w_push             = 1'b0;
    w_push_code        = '0;
    w_csi_drop         = 1'b0;
    if (w_byte_valid) begin
      w_tmo_next = '0;
      case (r_state)
        IDLE: begin
          if (w_byte == ASCII_ESC) begin
            w_state_next = ESC;
          end else begin
            w_push      = 1'b1;
            w_push_code = {1'b0, w_byte};
          end
        end
        ESC: begin
          if (w_byte == ASCII_LBRACKET) begin
            w_state_next = CSI;
          end else begin
            w_push            = 1'b1;
            w_push_code       = KEY_ESC;
            w_pend_valid_next = 1'b1;
            w_pend_data_next  = w_byte;
            w_state_next      = IDLE;
          end
        end
        CSI: begin
          case (w_byte)
            8'h41: begin w_push = 1'b1; w_push_code = KEY_UP;    w_state_next = IDLE; end
            8'h42: begin w_push = 1'b1; w_push_code = KEY_DOWN;  w_state_next = IDLE; end
            8'h43: begin w_push = 1'b1; w_push_code = KEY_RIGHT; w_state_next = IDLE; end
            8'h44: begin w_push = 1'b1; w_push_code = KEY_LEFT;  w_state_next = IDLE; end
            8'h48: begin w_push = 1'b1; w_push_code = KEY_HOME;  w_state_next = IDLE; end
            8'h46: begin w_push = 1'b1; w_push_code = KEY_END;   w_state_next = IDLE; end
            default: begin
              if (is_param_byte(w_byte)) begin
                w_param_digit_next = w_byte;
                w_param_len_next   = 2'd1;
                w_state_next       = PARAM;
              end else if (is_final_byte(w_byte) || !is_csi_byte(w_byte)) begin
                w_csi_drop   = 1'b1;
                w_state_next = IDLE;
              end
            end
          endcase
        end
        PARAM: begin
          if (is_param_byte(w_byte)) begin
            if (r_param_len != 2'd2) begin
              w_param_len_next = r_param_len + 2'd1;
            end
          end else if (is_final_byte(w_byte) || !is_csi_byte(w_byte)) begin
            w_state_next = IDLE;
            w_csi_drop   = 1'b1;
            // Only a single-digit ESC[n~ maps to a key.
            if ((w_byte == ASCII_TILDE) && (r_param_len == 2'd1)) begin
              case (r_param_digit)
                8'h31: begin w_push = 1'b1; w_push_code = KEY_HOME;   w_csi_drop = 1'b0; end
                8'h33: begin w_push = 1'b1; w_push_code = KEY_DELETE; w_csi_drop = 1'b0; end
                8'h34: begin w_push = 1'b1; w_push_code = KEY_END;    w_csi_drop = 1'b0; end
                default: ;
              endcase
            end
          end
        end
        default: w_state_next = IDLE;
      endcase
    end else if (w_tmo_fire) begin
      w_tmo_next   = '0;
      w_state_next = IDLE;
      if (r_state == ESC) begin
        w_push      = 1'b1;
        w_push_code = KEY_ESC;
      end else begin
        w_csi_drop = 1'b1;
      end
    end
  end

  assign w_pop       = ~w_empty & i_key_ready;
  assign w_fifo_drop = r_push & w_full & ~w_pop;

  key_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_key_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_push),
    .i_data  (r_push_code),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_fifo_count)
  );

  // A new loss in the same cycle as the clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_fifo_drop || w_strobe_lost) begin
      r_overflow <= 1'b1;
    end else if (i_overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign o_key_valid = ~w_empty;
  assign o_key_code  = w_head;
  assign o_overflow  = r_overflow;

`ifdef KEY_DROP_CNT_EN
  logic [7:0] r_drop_cnt;
  logic [1:0] w_drop_inc;
  logic [8:0] w_drop_sum;

  assign w_drop_inc = 2'(w_fifo_drop) + 2'(w_strobe_lost) + 2'(w_csi_drop);
  assign w_drop_sum = (i_overflow_clr ? 9'd0 : {1'b0, r_drop_cnt}) + {7'd0, w_drop_inc};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else begin
      r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  assign o_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_uart_key_decoder.sv
// Self-checking bench for uart_key_decoder: directed latency/boundary cases plus a randomized
// token stream whose expected keys come from a sequence-level table of escape sequences.
module tb_uart_key_decoder;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       key_valid;
  logic [8:0] key_code;
  logic       key_ready = 1'b0;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       ovf_clr = 1'b0;
`ifdef KEY_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int         n_tests = 0;
  int         n_fail = 0;
  int         n_pops = 0;
  int         exp_drops = 0;
  int         n0;
  bit         rnd_ready = 1'b0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  uart_key_decoder #(
    .FIFO_DEPTH  (DEPTH),
    .ESC_TIMEOUT (TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_rx_data_valid (rx_valid),
    .i_rx_data       (rx_data),
    .o_key_valid     (key_valid),
    .o_key_code      (key_code),
    .i_key_ready     (key_ready),
    .o_fifo_count    (fifo_count),
    .o_overflow      (overflow),
    .i_overflow_clr  (ovf_clr)
`ifdef KEY_DROP_CNT_EN
    ,
    .o_drop_cnt      (drop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Every accepted key must be the next one the model expects.
  always @(negedge clk) begin
    if (!reset && key_valid && key_ready) begin
      n_pops++;
      check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("pop_code", 32'(key_code), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) begin
      key_ready = key_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic gsend(input logic [7:0] b);
    send(b);
    idle(int'($urandom_range(5, 11)));
  endtask

  task automatic pulse_clr();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
  endtask

  function automatic logic [8:0] csi_letter_key(input logic [7:0] c);
    case (c)
      8'h41:   return 9'h100;
      8'h42:   return 9'h101;
      8'h43:   return 9'h102;
      8'h44:   return 9'h103;
      8'h48:   return 9'h104;
      8'h46:   return 9'h105;
      default: return 9'h000;
    endcase
  endfunction

  function automatic logic [8:0] tilde_key(input logic [7:0] d);
    case (d)
      8'h31:   return 9'h104;
      8'h33:   return 9'h106;
      8'h34:   return 9'h105;
      default: return 9'h000;
    endcase
  endfunction

  function automatic logic [7:0] rnd_param();
    int r = int'($urandom_range(0, 10));
    return (r == 10) ? 8'h3B : 8'(8'h30 + r);
  endfunction

  // One random token: its bytes, and the keys/drops that escape-sequence rules imply.
  task automatic rnd_token();
    int         kind = int'($urandom_range(0, 8));
    int         np;
    logic [7:0] b;
    logic [8:0] k;
    case (kind)
      0: begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h1B) b = 8'h1A;
        exp_q.push_back({1'b0, b});
        gsend(b);
      end
      1: begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h1B || b == 8'h5B) b = 8'h78;
        exp_q.push_back(9'h107);
        exp_q.push_back({1'b0, b});
        gsend(8'h1B); gsend(b);
      end
      2: begin
        case ($urandom_range(0, 5))
          0: b = 8'h41; 1: b = 8'h42; 2: b = 8'h43;
          3: b = 8'h44; 4: b = 8'h48; default: b = 8'h46;
        endcase
        exp_q.push_back(csi_letter_key(b));
        gsend(8'h1B); gsend(8'h5B); gsend(b);
      end
      3: begin
        b = 8'(8'h30 + $urandom_range(0, 9));
        k = tilde_key(b);
        if (k != 9'h000) exp_q.push_back(k);
        else exp_drops++;
        gsend(8'h1B); gsend(8'h5B); gsend(b); gsend(8'h7E);
      end
      4: begin
        np = int'($urandom_range(2, 3));
        gsend(8'h1B); gsend(8'h5B);
        for (int i = 0; i < np; i++) gsend(rnd_param());
        gsend(8'($urandom_range(8'h40, 8'h7E)));
        exp_drops++;
      end
      5: begin
        gsend(8'h1B); gsend(8'h5B);
        if ($urandom_range(0, 1) == 1) gsend(rnd_param());
        np = int'($urandom_range(0, 8'h60));
        b  = (np < 8'h20) ? 8'(np) : 8'(8'h7F + np - 8'h20);
        gsend(b);
        exp_drops++;
      end
      6: begin
        do b = 8'($urandom_range(8'h40, 8'h7E)); while (csi_letter_key(b) != 9'h000);
        gsend(8'h1B); gsend(8'h5B); gsend(b);
        exp_drops++;
      end
      7: begin
        exp_q.push_back(9'h107);
        gsend(8'h1B);
        idle(30);
      end
      default: begin
        gsend(8'h1B); gsend(8'h5B);
        if ($urandom_range(0, 1) == 1) gsend(rnd_param());
        idle(30);
        exp_drops++;
      end
    endcase
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    idle(3);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_code", 32'(key_code), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
`ifdef KEY_DROP_CNT_EN
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    reset = 1'b0;
    step();

    // Plain bytes: key_valid two cycles after the strobe.
    key_ready = 1'b1;
    exp_q.push_back(9'h061);
    send(8'h61);
    check("plain_lat_c1", 32'(key_valid), 32'd0);
    step();
    check("plain_lat_c2", 32'(key_valid), 32'd1);
    check("plain_head_61", 32'(key_code), 32'h061);
    idle(48);
    exp_q.push_back(9'h00D);
    send(8'h0D);
    check("plain_lat_c1b", 32'(key_valid), 32'd0);
    step();
    check("plain_lat_c2b", 32'(key_valid), 32'd1);
    check("plain_head_0d", 32'(key_code), 32'h00D);
    idle(5);

    // ESC[A and ESC[3~ give exactly UP then DELETE.
    n0 = n_pops;
    exp_q.push_back(9'h100);
    exp_q.push_back(9'h106);
    send(8'h1B); idle(2); send(8'h5B); idle(2); send(8'h41); idle(2);
    send(8'h1B); idle(2); send(8'h5B); idle(2); send(8'h33); idle(2); send(8'h7E);
    idle(10);
    check("csi_key_count", 32'(n_pops - n0), 32'd2);
    check("csi_queue_empty", 32'(exp_q.size()), 32'd0);

    // Lone ESC times out on cycle ESC_TIMEOUT.
    exp_q.push_back(9'h107);
    send(8'h1B);
    idle(TMO);
    check("tmo_not_yet", 32'(key_valid), 32'd0);
    step();
    check("tmo_fired", 32'(key_valid), 32'd1);
    check("tmo_key_esc", 32'(key_code), 32'h107);
    idle(3);

    // A byte on the timeout cycle itself wins: ESC then '[' after TMO-1 idle cycles.
    n0 = n_pops;
    exp_q.push_back(9'h101);
    send(8'h1B); idle(TMO - 1); send(8'h5B); idle(2); send(8'h42);
    idle(6);
    check("tmo_edge_count", 32'(n_pops - n0), 32'd1);
    check("tmo_edge_queue", 32'(exp_q.size()), 32'd0);

    // ESC followed by 'x': ESC then 'x' on consecutive cycles.
    key_ready = 1'b0;
    exp_q.push_back(9'h107);
    exp_q.push_back(9'h078);
    send(8'h1B); idle(2); send(8'h78);
    step();
    check("escx_count1", 32'(fifo_count), 32'd1);
    check("escx_head", 32'(key_code), 32'h107);
    step();
    check("escx_count2", 32'(fifo_count), 32'd2);
    key_ready = 1'b1;
    idle(5);
    check("escx_queue", 32'(exp_q.size()), 32'd0);

    // Modified-key sequence ESC[1;5C is dropped; decoder returns to IDLE.
    pulse_clr();
    send(8'h1B); send(8'h5B); send(8'h31); send(8'h3B); send(8'h35); send(8'h43);
    idle(5);
    check("mod_no_push", 32'(fifo_count), 32'd0);
    check("mod_no_valid", 32'(key_valid), 32'd0);
`ifdef KEY_DROP_CNT_EN
    check("mod_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    exp_q.push_back(9'h041);
    send(8'h41);
    idle(4);
    check("mod_idle_after", 32'(exp_q.size()), 32'd0);

    // Overflow: five bytes into a four-entry FIFO with no consumer.
    key_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < DEPTH) exp_q.push_back(9'(8'h30 + i));
      send(8'(8'h30 + i));
    end
    idle(3);
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head", 32'(key_code), 32'h030);
`ifdef KEY_DROP_CNT_EN
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
`endif
    key_ready = 1'b1;
    pulse_clr();
    check("ovf_cleared", 32'(overflow), 32'd0);
`ifdef KEY_DROP_CNT_EN
    check("ovf_drop_clr", 32'(drop_cnt), 32'd0);
`endif
    idle(6);
    check("ovf_drained", 32'(fifo_count), 32'd0);
    check("ovf_queue", 32'(exp_q.size()), 32'd0);

    // Strobe during a replay: replay wins, strobe lost with overflow.
    exp_q.push_back(9'h107);
    exp_q.push_back(9'h078);
    send(8'h1B); idle(2); send(8'h78); send(8'h79);
    check("replay_clash_ovf", 32'(overflow), 32'd1);
    idle(5);
    check("replay_clash_q", 32'(exp_q.size()), 32'd0);
    pulse_clr();

    // Reset mid-sequence with two keys queued.
    key_ready = 1'b0;
    send(8'h71); send(8'h72); send(8'h1B); send(8'h5B);
    idle(1);
    check("rstmid_pre_count", 32'(fifo_count), 32'd2);
    reset = 1'b1;
    #1;
    check("rstmid_valid", 32'(key_valid), 32'd0);
    check("rstmid_count", 32'(fifo_count), 32'd0);
    exp_q.delete();
    step();
    reset = 1'b0;
    key_ready = 1'b1;
    exp_q.push_back(9'h041);
    send(8'h41);
    idle(4);
    check("rstmid_plain_a", 32'(exp_q.size()), 32'd0);

    // Randomized token stream with a stalling consumer.
    pulse_clr();
    exp_drops = 0;
    rnd_ready = 1'b1;
    for (int t = 0; t < 300; t++) rnd_token();
    rnd_ready = 1'b0;
    key_ready = 1'b1;
    idle(40);
    check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
    check("rnd_no_overflow", 32'(overflow), 32'd0);
`ifdef KEY_DROP_CNT_EN
    check("rnd_drop_cnt", 32'(drop_cnt), 32'((exp_drops > 255) ? 255 : exp_drops));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
